// File: rtl/fwd_arbiter_pkg.sv
// Shared state encoding and elaboration helpers for the forwarder arbiter.
package fwd_arbiter_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] OFFER   = 2'd1;
  localparam logic [1:0] XFER    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fwd_arbiter_if.sv
// Core-side request/grant/done bundle plus the egress forwarder handshakes.
interface fwd_arbiter_if #(
  parameter int N_CORES = 4,
  parameter int SEL_W   = 2
);
  logic [N_CORES-1:0] req;
  logic [N_CORES-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic               fwd_rdy;
  logic               fwd_rdy_ack;
  logic               fwd_done;
  logic               fwd_done_ack;
  logic [N_CORES-1:0] core_done;
  logic [N_CORES-1:0] core_done_ack;
  logic               busy;

  modport master (
    input  req, fwd_rdy_ack, fwd_done, core_done_ack,
    output gnt, sel, fwd_rdy, fwd_done_ack, core_done, busy
  );

  modport slave (
    output req, fwd_rdy_ack, fwd_done, core_done_ack,
    input  gnt, sel, fwd_rdy, fwd_done_ack, core_done, busy
  );
endinterface

// File: rtl/fwd_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate req so rr_ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick #(
  parameter int N_CORES = 4,
  parameter int SEL_W   = 2
) (
  input  logic [N_CORES-1:0] req,
  input  logic [SEL_W-1:0]   rr_ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [N_CORES-1:0] rot;
  logic [SEL_W-1:0]   enc;
  int                 j;
  int                 s;

  always_comb begin
    rot = '0;
    j   = 0;
    for (int i = 0; i < N_CORES; i++) begin
      // rr_ptr is always < N_CORES, so one conditional subtract wraps it
      j = i + int'(rr_ptr);
      if (j >= N_CORES) j = j - N_CORES;
      rot[i] = req[SEL_W'(j)];
    end

    enc = '0;
    for (int i = N_CORES - 1; i >= 0; i--)
      if (rot[i]) enc = SEL_W'(i);

    s = int'(enc) + int'(rr_ptr);
    if (s >= N_CORES) s = s - N_CORES;
    idx   = SEL_W'(s);
    found = |req;
  end

endmodule

// File: rtl/fwd_arbiter.sv
// Round-robin owner of the shared egress forwarder: grant, offer, transfer,
// then release back to the granted core.
import fwd_arbiter_pkg::*;

module fwd_arbiter #(
  parameter int N_CORES = 4,
  parameter int SEL_W   = 2
) (
  input logic           clk,
  input logic           rst,
  fwd_arbiter_if.master bus
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CORES - 1);

  if (SEL_W != clog2(N_CORES)) begin : g_bad_sel_w
    $error("fwd_arbiter: SEL_W must equal clog2(N_CORES)");
  end

  logic [1:0]         state;
  logic [SEL_W-1:0]   rr_ptr;
  logic [SEL_W-1:0]   sel;
  logic [N_CORES-1:0] gnt;
  logic               found;
  logic [SEL_W-1:0]   idx;

  rr_pick #(.N_CORES(N_CORES), .SEL_W(SEL_W)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .found  (found),
    .idx    (idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      sel    <= '0;
      gnt    <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          sel   <= idx;
          gnt   <= N_CORES'(1) << idx;
          state <= OFFER;
        end
        // Handshake beats a same-edge request drop
        OFFER: if (bus.fwd_rdy_ack) begin
          state <= XFER;
        end else if (!bus.req[sel]) begin
          gnt   <= '0;
          state <= IDLE;
        end
        XFER: if (bus.fwd_done) state <= RELEASE;
        RELEASE: if (bus.core_done_ack[sel]) begin
          gnt    <= '0;
          rr_ptr <= (sel == LAST) ? '0 : sel + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt          = gnt;
  assign bus.sel          = sel;
  assign bus.fwd_rdy      = (state == OFFER);
  assign bus.fwd_done_ack = (state == XFER);
  assign bus.core_done    = (state == RELEASE) ? gnt : '0;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_fwd_arbiter.sv
// Directed checks of the forwarder arbiter: 4-core instance plus a 3-core
// instance for the non-power-of-2 wrap.
module tb_fwd_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fwd_arbiter_if #(.N_CORES(4), .SEL_W(2)) b4 ();
  fwd_arbiter_if #(.N_CORES(3), .SEL_W(2)) b3 ();

  fwd_arbiter #(.N_CORES(4), .SEL_W(2)) dut (.clk(clk), .rst(rst), .bus(b4));
  fwd_arbiter #(.N_CORES(3), .SEL_W(2)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    b4.req = '0; b4.fwd_rdy_ack = 1'b1; b4.fwd_done = 1'b1; b4.core_done_ack = '1;
    b3.req = '0; b3.fwd_rdy_ack = 1'b1; b3.fwd_done = 1'b1; b3.core_done_ack = '1;

    // 1: reset, then single core 2
    step(); step();
    chk("rst_gnt", 32'(b4.gnt), 32'h0);
    chk("rst_sel", 32'(b4.sel), 32'h0);
    chk("rst_busy_rdy_dack_cd", {28'h0, b4.busy, b4.fwd_rdy, b4.fwd_done_ack, |b4.core_done}, 32'h0);
    chk("rst_ptr", 32'(dut.rr_ptr), 32'h0);
    rst = 1'b0;
    b4.req = 4'b0100;
    step();
    chk("t1_gnt", 32'(b4.gnt), 32'h4);
    chk("t1_sel", 32'(b4.sel), 32'h2);
    chk("t1_offer", {30'h0, b4.fwd_rdy, b4.fwd_done_ack}, 32'h2);
    step();
    chk("t1_xfer", {30'h0, b4.fwd_rdy, b4.fwd_done_ack}, 32'h1);
    step();
    chk("t1_core_done", 32'(b4.core_done), 32'h4);
    b4.req = '0;
    step();
    chk("t1_idle", {27'h0, b4.busy, b4.gnt}, 32'h0);
    chk("t1_ptr", 32'(dut.rr_ptr), 32'h3);

    // 2: fairness with all cores requesting
    rst = 1'b1; step(); rst = 1'b0;
    b4.req = 4'b1111;
    step();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_gnt%0d", k), 32'(b4.gnt), 32'h1 << (k % 4));
      step(); step(); step(); step();
    end

    // 3: abort when req[1] drops in OFFER
    rst = 1'b1; b4.req = '0; step(); rst = 1'b0;
    b4.fwd_rdy_ack = 1'b0;
    b4.req = 4'b0010;
    step();
    chk("t3_sel", 32'(b4.sel), 32'h1);
    b4.req = '0;
    step();
    chk("t3_abort", {27'h0, b4.busy, b4.gnt}, 32'h0);
    chk("t3_ptr", 32'(dut.rr_ptr), 32'h0);

    // handshake and request drop on the same edge: handshake wins
    b4.req = 4'b0010;
    step();
    b4.fwd_rdy_ack = 1'b1;
    b4.fwd_done = 1'b0;
    b4.req = '0;
    step();
    chk("t3_tie", {27'h0, b4.fwd_done_ack, b4.gnt}, 32'h12);

    // 4: stall in XFER while other cores request
    b4.req = 4'b1101;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("t4_stall%0d", k), {27'h0, b4.fwd_done_ack, b4.gnt}, 32'h12);
    end
    b4.core_done_ack = 4'b1101;
    b4.fwd_done = 1'b1;
    step();
    chk("t4_release", 32'(b4.core_done), 32'h2);
    step();
    chk("t4_nonsel_ack", 32'(b4.core_done), 32'h2);

    // 5: reset during RELEASE
    rst = 1'b1;
    b4.core_done_ack = '1;
    b4.req = 4'b1111;
    step();
    chk("t5_outs", {22'h0, b4.busy, b4.fwd_rdy, b4.fwd_done_ack, b4.core_done, b4.gnt}, 32'h0);
    chk("t5_sel", 32'(b4.sel), 32'h0);
    rst = 1'b0;
    step();
    chk("t5_first", 32'(b4.gnt), 32'h1);

    // 6: three cores, req 101 alternates 0,2 and rr_ptr wraps 2 -> 0
    b3.req = 3'b101;
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t6_gnt%0d", k), 32'(b3.gnt), (k % 2 == 0) ? 32'h1 : 32'h4);
      step(); step(); step();
      chk($sformatf("t6_ptr%0d", k), 32'(dut3.rr_ptr), (k % 2 == 0) ? 32'h1 : 32'h0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
